// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a req/gnt/rvalid handshake.
//
// A request is accepted in the cycle where req_i and gnt_o are both high.
// The grant comes GNT_DELAY cycles after req_i is first seen (GNT_DELAY=0
// grants combinationally in the same cycle). The response arrives one cycle
// after the grant. Accesses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS)
// are still granted and answered, but they return err_o=1 and never touch
// storage.
//
// Optional feature: define MEM_RESP_RANDOM_STALL_EN to add an 8-bit LFSR
// that can defer a grant that is due by one cycle at a time.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (storage is not cleared)
//   req_i     request from the initiator
//   gnt_o     grant (combinational from state and req_i)
//   rvalid_o  response valid, one cycle per accepted request
//   we_i      1 = write, 0 = read
//   be_i      byte enables, bit n selects byte n
//   addr_i    byte address (bits [1:0] ignored)
//   wdata_i   write data
//   rdata_o   read data (0 for writes and errors), valid with rvalid_o
//   err_o     out-of-range access flag, valid with rvalid_o
module mem_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0,
    parameter int                    GNT_DELAY   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o
);

    localparam int                    NB    = DATA_WIDTH / 8;
    localparam int                    IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * DEPTH_WORDS);
    localparam logic [3:0]            DELAY = 4'(GNT_DELAY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH_WORDS];
    logic                    rvalid_r;
    logic                    err_r;
    logic [DATA_WIDTH-1:0]   rdata_r;

    logic                    due_s;
    logic                    stall_s;
    logic                    gnt_s;
    logic                    borrow_s;
    logic [ADDR_WIDTH-1:0]   offset_s;
    logic                    in_range_s;
    logic [IDX_W-1:0]        idx_s;

    // Address decode: a borrow means the address lies below BASE_ADDR.
    always_comb begin
        {borrow_s, offset_s} = {1'b0, addr_i} - {1'b0, BASE_ADDR};
        in_range_s = !borrow_s && (offset_s < SPAN);
        idx_s      = offset_s[IDX_W+1:2];
    end

    // A grant is due when the request is present and the delay has elapsed.
    always_comb begin
        due_s = 1'b0;
        case (state_r)
            IDLE, RESP: due_s = req_i && (DELAY == 4'd0);
            WAIT:       due_s = req_i && (cnt_r == 4'd1);
            default:    due_s = 1'b0;
        endcase
    end

`ifdef MEM_RESP_RANDOM_STALL_EN
    logic [7:0] lfsr_r;

    // Fibonacci LFSR, taps 8,6,5,4; bit 0 high defers a due grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    assign stall_s = lfsr_r[0];
`else
    assign stall_s = 1'b0;
`endif

    // Reset masks the grant so nothing is accepted or written on a reset edge.
    assign gnt_s = due_s && !stall_s && !rst;
    assign gnt_o = gnt_s;

    // Handshake FSM plus registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= '0;
        end else begin
            rvalid_r <= gnt_s;
            err_r    <= gnt_s && !in_range_s;
            rdata_r  <= (gnt_s && !we_i && in_range_s) ? mem_r[idx_s] : '0;
            case (state_r)
                IDLE, RESP: begin
                    if (!req_i) begin
                        state_r <= IDLE;
                    end else if (DELAY == 4'd0) begin
                        // A stalled grant simply retries from IDLE next cycle.
                        state_r <= gnt_s ? RESP : IDLE;
                    end else begin
                        cnt_r   <= DELAY;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req_i) begin
                        cnt_r   <= 4'd0;
                        state_r <= IDLE;
                    end else if (cnt_r == 4'd1) begin
                        // Counter parks at 1 while a due grant is stalled.
                        if (gnt_s) begin
                            cnt_r   <= 4'd0;
                            state_r <= RESP;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    cnt_r   <= 4'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Byte-enabled write on the grant edge; storage is never reset.
    always_ff @(posedge clk) begin
        if (gnt_s && we_i && in_range_s) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Responses are suppressed while reset is held, including one already queued.
    assign rvalid_o = rvalid_r && !rst;
    assign err_o    = err_r && !rst;
    assign rdata_o  = rst ? '0 : rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder.
// Three instances share one clock: A (GNT_DELAY=1), B (GNT_DELAY=0), C (GNT_DELAY=3).
// With MEM_RESP_RANDOM_STALL_EN defined, the fixed-latency sequences on A and C
// are skipped and B runs an additional 64 reads against an LFSR stall model.
module tb_mem_responder;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic [2:0]       rst;
    logic [2:0]       req;
    logic [2:0]       we;
    logic [2:0][3:0]  be;
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wdata;

    logic        gnt_a, gnt_b, gnt_c;
    logic        rv_a, rv_b, rv_c;
    logic        err_a, err_b, err_c;
    logic [31:0] rd_a, rd_b, rd_c;

    wire [2:0]       gnt_v   = {gnt_c, gnt_b, gnt_a};
    wire [2:0]       rv_v    = {rv_c, rv_b, rv_a};
    wire [2:0]       err_v   = {err_c, err_b, err_a};
    wire [2:0][31:0] rdata_v = {rd_c, rd_b, rd_a};

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_responder #(.GNT_DELAY(1)) u_a (
        .clk(clk), .rst(rst[0]), .req_i(req[0]), .gnt_o(gnt_a), .rvalid_o(rv_a),
        .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
        .rdata_o(rd_a), .err_o(err_a));

    mem_responder #(.GNT_DELAY(0)) u_b (
        .clk(clk), .rst(rst[1]), .req_i(req[1]), .gnt_o(gnt_b), .rvalid_o(rv_b),
        .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .rdata_o(rd_b), .err_o(err_b));

    mem_responder #(.GNT_DELAY(3)) u_c (
        .clk(clk), .rst(rst[2]), .req_i(req[2]), .gnt_o(gnt_c), .rvalid_o(rv_c),
        .we_i(we[2]), .be_i(be[2]), .addr_i(addr[2]), .wdata_i(wdata[2]),
        .rdata_o(rd_c), .err_o(err_c));

`ifdef MEM_RESP_RANDOM_STALL_EN
    logic [7:0] m_lfsr;
    // Reference LFSR for instance B, built from the tap list and seed.
    always @(posedge clk) begin
        if (rst[1]) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    function automatic logic stall_b();
        return m_lfsr[0];
    endfunction
`else
    function automatic logic stall_b();
        return 1'b0;
    endfunction
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction; call right after a negedge, returns at negedge+1.
    task automatic xact(input int k, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                        input logic [31:0] exp_rd, input logic exp_err, input string name);
        int   lat;
        logic got;
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
        lat = 0;
        got = 1'b0;
        while (!got && lat <= 20) begin
            #1;
            if (gnt_v[k]) got = 1'b1;
            else begin
                lat++;
                @(negedge clk);
            end
        end
        chk({name, "_granted"}, {31'd0, got}, 32'd1);
        if (got) begin
            chk({name, "_latency"}, lat, exp_lat);
            @(posedge clk);
            @(negedge clk);
            req[k] = 1'b0;
            #1;
            chk({name, "_rvalid"}, {31'd0, rv_v[k]}, 32'd1);
            chk({name, "_rdata"}, rdata_v[k], exp_rd);
            chk({name, "_err"}, {31'd0, err_v[k]}, {31'd0, exp_err});
            @(negedge clk);
            #1;
            chk({name, "_rvalid_once"}, {31'd0, rv_v[k]}, 32'd0);
        end else begin
            req[k] = 1'b0;
        end
    endtask

    vec_t va[14];
    vec_t qb[$];
    logic [31:0] bvals[4];

    initial begin
        int   i, pending, cyc;
        logic exp_g;

        // Instance A vectors (GNT_DELAY=1, latency 1).
        va[0]  = '{1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        va[1]  = '{1'b0, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        va[2]  = '{1'b1, 4'hF, 32'h20,   32'h11223344, 32'h0,        1'b0};
        va[3]  = '{1'b1, 4'h5, 32'h20,   32'hAABBCCDD, 32'h0,        1'b0};
        va[4]  = '{1'b0, 4'hF, 32'h20,   32'h0,        32'h11BB33DD, 1'b0};
        va[5]  = '{1'b1, 4'hF, 32'h0,    32'hCAFEF00D, 32'h0,        1'b0};
        va[6]  = '{1'b0, 4'hF, 32'h1000, 32'h0,        32'h0,        1'b1};
        va[7]  = '{1'b1, 4'hF, 32'h1000, 32'h12345678, 32'h0,        1'b1};
        va[8]  = '{1'b0, 4'hF, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0};
        va[9]  = '{1'b1, 4'hF, 32'h24,   32'h77665544, 32'h0,        1'b0};
        va[10] = '{1'b1, 4'h0, 32'h24,   32'hFFFFFFFF, 32'h0,        1'b0};
        va[11] = '{1'b0, 4'hF, 32'h24,   32'h0,        32'h77665544, 1'b0};
        va[12] = '{1'b1, 4'hF, 32'hFFC,  32'h0BADCAFE, 32'h0,        1'b0};
        va[13] = '{1'b0, 4'hF, 32'hFFF,  32'h0,        32'h0BADCAFE, 1'b0};

        // Instance B back-to-back ops with req held (GNT_DELAY=0).
        bvals[0] = 32'h11110000; bvals[1] = 32'h22220001;
        bvals[2] = 32'h33330002; bvals[3] = 32'h44440003;
        for (int j = 0; j < 4; j++) qb.push_back('{1'b1, 4'hF, 32'h40 + 32'(4*j), bvals[j], 32'h0, 1'b0});
        qb.push_back('{1'b0, 4'hF, 32'h4C, 32'h0, bvals[3], 1'b0});
        for (int j = 0; j < 4; j++) qb.push_back('{1'b0, 4'hF, 32'h40 + 32'(4*j), 32'h0, bvals[j], 1'b0});
        qb.push_back('{1'b0, 4'hF, 32'h2000, 32'h0, 32'h0, 1'b1});
`ifdef MEM_RESP_RANDOM_STALL_EN
        for (int j = 0; j < 64; j++) qb.push_back('{1'b0, 4'hF, 32'h40 + 32'(4*(j%4)), 32'h0, bvals[j%4], 1'b0});
`endif

        // Reset with requests asserted: nothing may be granted.
        rst = 3'b111; req = 3'b111; we = 3'b000; be = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_gnt%0d", k), {31'd0, gnt_v[k]}, 32'd0);
            chk($sformatf("rst_rvalid%0d", k), {31'd0, rv_v[k]}, 32'd0);
            chk($sformatf("rst_rdata%0d", k), rdata_v[k], 32'd0);
            chk($sformatf("rst_err%0d", k), {31'd0, err_v[k]}, 32'd0);
        end
        @(negedge clk);
        rst = 3'b000; req = 3'b000;
        @(negedge clk);

`ifndef MEM_RESP_RANDOM_STALL_EN
        for (int v = 0; v < 14; v++)
            xact(0, va[v].we, va[v].be, va[v].addr, va[v].wdata, 1,
                 va[v].exp_rdata, va[v].exp_err, $sformatf("a_v%0d", v));
`endif

        // Instance B: one op presented per cycle, grant predicted per cycle.
        @(negedge clk);
        i = 0; pending = -1; cyc = 0;
        while ((i < qb.size() || pending >= 0) && cyc < 1000) begin
            if (i < qb.size()) begin
                req[1] = 1'b1; we[1] = qb[i].we; be[1] = qb[i].be;
                addr[1] = qb[i].addr; wdata[1] = qb[i].wdata;
            end else begin
                req[1] = 1'b0;
            end
            #1;
            if (pending >= 0) begin
                chk($sformatf("b_op%0d_rvalid", pending), {31'd0, rv_b}, 32'd1);
                chk($sformatf("b_op%0d_rdata", pending), rd_b, qb[pending].exp_rdata);
                chk($sformatf("b_op%0d_err", pending), {31'd0, err_b}, {31'd0, qb[pending].exp_err});
                pending = -1;
            end else begin
                chk($sformatf("b_idle_rvalid_c%0d", cyc), {31'd0, rv_b}, 32'd0);
            end
            exp_g = (i < qb.size()) && !stall_b();
            chk($sformatf("b_gnt_c%0d", cyc), {31'd0, gnt_b}, {31'd0, exp_g});
            if (gnt_b) begin
                pending = i;
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("b_all_done", i, qb.size());
        #1;
        chk("b_final_rvalid", {31'd0, rv_b}, 32'd0);
        @(negedge clk);

`ifndef MEM_RESP_RANDOM_STALL_EN
        // Instance C: latency 3, abort, reset on grant edge, reset after grant.
        xact(2, 1'b1, 4'hF, 32'h80, 32'h01020304, 3, 32'h0, 1'b0, "c_wr80");
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h80; wdata[2] = 32'hFFFFFFFF;
        for (int c = 0; c < 2; c++) begin
            #1 chk("c_abort_nogrant", {31'd0, gnt_c}, 32'd0);
            @(negedge clk);
        end
        req[2] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("c_abort_gnt", {31'd0, gnt_c}, 32'd0);
            chk("c_abort_rvalid", {31'd0, rv_c}, 32'd0);
            @(negedge clk);
        end
        xact(2, 1'b0, 4'hF, 32'h80, 32'h0, 3, 32'h01020304, 1'b0, "c_rd80_after_abort");

        xact(2, 1'b1, 4'hF, 32'h84, 32'h0A0B0C0D, 3, 32'h0, 1'b0, "c_wr84");
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h84; wdata[2] = 32'h55555555;
        for (int c = 0; c < 3; c++) begin
            #1 chk("c_rstwr_wait", {31'd0, gnt_c}, 32'd0);
            @(negedge clk);
        end
        rst[2] = 1'b1;
        #1 chk("c_rstwr_gnt_blocked", {31'd0, gnt_c}, 32'd0);
        @(negedge clk);
        rst[2] = 1'b0; req[2] = 1'b0;
        #1 chk("c_rstwr_rvalid", {31'd0, rv_c}, 32'd0);
        @(negedge clk);
        #1 chk("c_rstwr_rvalid2", {31'd0, rv_c}, 32'd0);
        @(negedge clk);
        xact(2, 1'b0, 4'hF, 32'h84, 32'h0, 3, 32'h0A0B0C0D, 1'b0, "c_rd84_after_rst");

        req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'h84;
        for (int c = 0; c < 3; c++) begin
            #1 chk("c_rstrd_wait", {31'd0, gnt_c}, 32'd0);
            @(negedge clk);
        end
        #1 chk("c_rstrd_gnt", {31'd0, gnt_c}, 32'd1);
        @(negedge clk);
        rst[2] = 1'b1; req[2] = 1'b0;
        #1;
        chk("c_rstrd_rvalid", {31'd0, rv_c}, 32'd0);
        chk("c_rstrd_rdata", rd_c, 32'd0);
        chk("c_rstrd_err", {31'd0, err_c}, 32'd0);
        @(negedge clk);
        rst[2] = 1'b0;
        #1 chk("c_rstrd_rvalid_after", {31'd0, rv_c}, 32'd0);
        @(negedge clk);
        xact(2, 1'b0, 4'hF, 32'h80, 32'h0, 3, 32'h01020304, 1'b0, "c_rd80_recover");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
